hilo_unit: RTL and testbench

Parametrised HI/LO register unit with an integrated multi-cycle multiply/divide engine for the 5-stage pipeline CPU. It executes MULT/MULTU/DIV/DIVU iteratively into a 2×WIDTH result held in HI/LO, and handles MTHI/MTLO writes. It exposes a busy/done handshake so the pipeline can stall on MFHI/MFLO and on new mult/div issues. It sits beside the EX stage and replaces the plain HI/LO latch that was loaded from an external divider.

---
 rtl/hilo_if.sv | 24 ++
 rtl/hilo_unit.sv | 200 ++++++++++++++++++++
 tb/tb_hilo_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hilo_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply/divide unit.
interface hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit with an iterative shift-add multiplier and restoring divider.
// Define HILO_MUL_EN to build the multiplier; otherwise MULT/MULTU decode as no-ops.
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  hilo_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_opb;
  logic           r_sign_a;
  logic           r_sign_b;
  logic           r_is_div;
  logic           r_dbz;
  logic           r_busy;
  logic           r_done;
  logic           r_dbz_pulse;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;

  logic           w_issue;
  logic           w_op_mthi;
  logic           w_op_mtlo;
  logic           w_op_div;
  logic           w_op_mul;
  logic           w_op_signed;
  logic           w_start_eng;
  logic           w_b_zero;
  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic [W:0]     w_div_rem_sh;
  logic [W:0]     w_div_trial;
  logic [2*W-1:0] w_div_next;
  logic [2*W-1:0] w_iter_next;
  logic [W-1:0]   w_fin_quot;
  logic [W-1:0]   w_fin_rem;
  logic [W-1:0]   w_fin_hi;
  logic [W-1:0]   w_fin_lo;
`ifdef HILO_MUL_EN
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;
  logic [2*W-1:0] w_fin_prod;
`endif

  assign w_issue     = (r_state == S_IDLE) && bus.start;
  assign w_op_mthi   = (bus.op == 3'b000);
  assign w_op_mtlo   = (bus.op == 3'b001);
  assign w_op_div    = (bus.op == 3'b100) || (bus.op == 3'b101);
`ifdef HILO_MUL_EN
  assign w_op_mul    = (bus.op == 3'b010) || (bus.op == 3'b011);
`else
  assign w_op_mul    = 1'b0;
`endif
  // MULT (010) and DIV (100) are the signed variants
  assign w_op_signed = ~bus.op[0];
  assign w_start_eng = w_issue && (w_op_div || w_op_mul);
  assign w_b_zero    = (bus.b == {W{1'b0}});
  assign w_abs_a     = (w_op_signed && bus.a[W-1]) ? (~bus.a + {{(W-1){1'b0}}, 1'b1}) : bus.a;
  assign w_abs_b     = (w_op_signed && bus.b[W-1]) ? (~bus.b + {{(W-1){1'b0}}, 1'b1}) : bus.b;

  // Next-state decode for the IDLE/RUN/FINISH sequencer
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_eng) begin
          w_state_next = (w_op_div && w_b_zero) ? S_FINISH : S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST) begin
          w_state_next = S_FINISH;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // One iteration step plus the final sign fix-up; r_acc holds {remainder, quotient} or the product
  always_comb begin
    w_div_rem_sh = r_acc[2*W-1:W-1];
    w_div_trial  = w_div_rem_sh - {1'b0, r_opb};
    if (w_div_trial[W]) begin
      w_div_next = {w_div_rem_sh[W-1:0], r_acc[W-2:0], 1'b0};
    end else begin
      w_div_next = {w_div_trial[W-1:0], r_acc[W-2:0], 1'b1};
    end
    w_fin_quot = (r_sign_a ^ r_sign_b) ? (~r_acc[W-1:0] + {{(W-1){1'b0}}, 1'b1}) : r_acc[W-1:0];
    w_fin_rem  = r_sign_a ? (~r_acc[2*W-1:W] + {{(W-1){1'b0}}, 1'b1}) : r_acc[2*W-1:W];
`ifdef HILO_MUL_EN
    w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : {(W+1){1'b0}});
    w_mul_next = {w_mul_sum, r_acc[W-1:1]};
    w_fin_prod = (r_sign_a ^ r_sign_b) ? (~r_acc + {{(2*W-1){1'b0}}, 1'b1}) : r_acc;
    if (r_is_div) begin
      w_iter_next = w_div_next;
      w_fin_hi    = w_fin_rem;
      w_fin_lo    = w_fin_quot;
    end else begin
      w_iter_next = w_mul_next;
      w_fin_hi    = w_fin_prod[2*W-1:W];
      w_fin_lo    = w_fin_prod[W-1:0];
    end
`else
    w_iter_next = w_div_next;
    w_fin_hi    = w_fin_rem;
    w_fin_lo    = w_fin_quot;
`endif
  end

  // Operand latch, iteration, HI/LO writes and handshake pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= {CW{1'b0}};
      r_acc       <= {(2*W){1'b0}};
      r_opb       <= {W{1'b0}};
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_is_div    <= 1'b0;
      r_dbz       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
      r_hi        <= {W{1'b0}};
      r_lo        <= {W{1'b0}};
    end else begin
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue && w_op_mthi) begin
            r_hi <= bus.a;
          end
          if (w_issue && w_op_mtlo) begin
            r_lo <= bus.a;
          end
          if (w_start_eng) begin
            r_busy   <= 1'b1;
            r_cnt    <= {CW{1'b0}};
            r_acc    <= {{W{1'b0}}, w_abs_a};
            r_opb    <= w_abs_b;
            r_sign_a <= w_op_signed & bus.a[W-1];
            r_sign_b <= w_op_signed & bus.b[W-1];
            r_is_div <= w_op_div;
            r_dbz    <= w_op_div & w_b_zero;
          end
        end
        S_RUN: begin
          r_acc <= w_iter_next;
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
        S_FINISH: begin
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_dbz_pulse <= r_dbz;
          if (!r_dbz) begin
            r_hi <= w_fin_hi;
            r_lo <= w_fin_lo;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz_pulse;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit at WIDTH=32 (both HILO_MUL_EN builds).
module tb_hilo_unit;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  hilo_if #(.WIDTH(32)) bus ();

  hilo_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one start for a single edge; returns 1 time unit after the sampling edge E0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen, capped at 100.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mt();
    issue(3'b000, 32'h12345678, 32'h0);
    issue(3'b001, 32'h9ABCDEF0, 32'h0);
    n_checks++; if (bus.hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi got %h exp 12345678", bus.hi); end
    n_checks++; if (bus.lo !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo got %h exp 9abcdef0", bus.lo); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mt_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_div();
    int n;
    issue(3'b100, 32'd7, 32'hFFFFFFFE);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL div_busy got %b exp 1", bus.busy); end
    wait_done(n);
    n_checks++; if (n != 33) begin n_fail++; $display("FAIL div_latency got %0d exp 33", n); end
    n_checks++; if (bus.lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got %h exp fffffffd", bus.lo); end
    n_checks++; if (bus.hi !== 32'h00000001) begin n_fail++; $display("FAIL div_hi got %h exp 00000001", bus.hi); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL div_done_busy got %b exp 0", bus.busy); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL div_dbz got %b exp 0", bus.div_by_zero); end
    issue(3'b101, 32'hFFFFFFFF, 32'h10);
    wait_done(n);
    n_checks++; if (n != 33) begin n_fail++; $display("FAIL divu_latency got %0d exp 33", n); end
    n_checks++; if (bus.lo !== 32'h0FFFFFFF) begin n_fail++; $display("FAIL divu_lo got %h exp 0fffffff", bus.lo); end
    n_checks++; if (bus.hi !== 32'h0000000F) begin n_fail++; $display("FAIL divu_hi got %h exp 0000000f", bus.hi); end
    @(posedge clk); #1;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got %b exp 0", bus.done); end
  endtask

  task automatic test_mul();
    int n;
`ifdef HILO_MUL_EN
    issue(3'b010, 32'hFFFFFFFD, 32'd5);
    wait_done(n);
    n_checks++; if (n != 33) begin n_fail++; $display("FAIL mult_latency got %0d exp 33", n); end
    n_checks++; if (bus.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
    n_checks++; if (bus.lo !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_lo got %h exp fffffff1", bus.lo); end
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    n_checks++; if (bus.hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi got %h exp fffffffe", bus.hi); end
    n_checks++; if (bus.lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo got %h exp 00000001", bus.lo); end
`else
    issue(3'b000, 32'h11, 32'h0);
    issue(3'b001, 32'h22, 32'h0);
    issue(3'b010, 32'hFFFFFFFD, 32'd5);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mult_off_busy got %b exp 0", bus.busy); end
    wait_done(n);
    n_checks++; if (n != 100) begin n_fail++; $display("FAIL mult_off_done got done after %0d exp none", n); end
    n_checks++; if (bus.hi !== 32'h11) begin n_fail++; $display("FAIL mult_off_hi got %h exp 00000011", bus.hi); end
    n_checks++; if (bus.lo !== 32'h22) begin n_fail++; $display("FAIL mult_off_lo got %h exp 00000022", bus.lo); end
`endif
  endtask

  task automatic test_div_edge();
    int n;
    issue(3'b000, 32'hA, 32'h0);
    issue(3'b001, 32'hB, 32'h0);
    issue(3'b101, 32'd55, 32'h0);
    wait_done(n);
    n_checks++; if (n != 1) begin n_fail++; $display("FAIL dbz_latency got %0d exp 1", n); end
    n_checks++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got %b exp 1", bus.div_by_zero); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dbz_busy got %b exp 0", bus.busy); end
    n_checks++; if (bus.hi !== 32'hA) begin n_fail++; $display("FAIL dbz_hi got %h exp 0000000a", bus.hi); end
    n_checks++; if (bus.lo !== 32'hB) begin n_fail++; $display("FAIL dbz_lo got %h exp 0000000b", bus.lo); end
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    n_checks++; if (bus.lo !== 32'h80000000) begin n_fail++; $display("FAIL divovf_lo got %h exp 80000000", bus.lo); end
    n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL divovf_hi got %h exp 0", bus.hi); end
  endtask

  task automatic test_mt_during_run();
    int n;
    issue(3'b000, 32'h55, 32'h0);
    issue(3'b101, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    issue(3'b000, 32'hDEAD, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (bus.hi !== 32'h55) begin n_fail++; $display("FAIL mt_in_run_hi got %h exp 00000055", bus.hi); end
    wait_done(n);
    n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL mt_in_run_final_hi got %h exp 00000002", bus.hi); end
    n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL mt_in_run_final_lo got %h exp 0000000e", bus.lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'b100, 32'd7, 32'hFFFFFFFE);
    wait_done(n);
    issue(3'b101, 32'd100, 32'd7);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy %b exp 1", bus.busy); end
    wait_done(n);
    n_checks++; if (n != 33) begin n_fail++; $display("FAIL b2b_latency got %0d exp 33", n); end
    n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL b2b_lo got %h exp 0000000e", bus.lo); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    issue(3'b101, 32'hFFFFFFFF, 32'h3);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL midrst_hi got %h exp 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL midrst_lo got %h exp 0", bus.lo); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b101, 32'd100, 32'd7);
    wait_done(n);
    n_checks++; if (n != 33) begin n_fail++; $display("FAIL post_rst_latency got %0d exp 33", n); end
    n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL post_rst_lo got %h exp 0000000e", bus.lo); end
    n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL post_rst_hi got %h exp 00000002", bus.hi); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b110;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    test_reset();
    test_mt();
    test_div();
    test_mul();
    test_div_edge();
    test_mt_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
